// File: rtl/lr_shift_arbiter.sv
// Round-robin arbiter sharing one logical left/right shifter between requesters A and B.
// One-cycle accept-to-result latency with a single result slot; both readies drop while the slot is full and o_ready is low.
module lr_shift_arbiter #(
   parameter int width = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      a_valid,
   output logic                      a_ready,
   input  logic [width-1:0]          a_bits,
   input  logic [$clog2(width)-1:0]  a_shift,
   input  logic                      a_left,
   input  logic                      b_valid,
   output logic                      b_ready,
   input  logic [width-1:0]          b_bits,
   input  logic [$clog2(width)-1:0]  b_shift,
   input  logic                      b_left,
   output logic                      o_valid,
   input  logic                      o_ready,
   output logic [width-1:0]          o_bits,
   output logic                      o_id
);

   localparam int SW = $clog2(width);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]       state;
   logic             last_grant;
   logic             can_load;
   logic             gnt_vld;
   logic             gnt_id;
   logic             accept;
   logic [width-1:0] sel_bits;
   logic [SW-1:0]    sel_shift;
   logic             sel_left;
   logic [width-1:0] shifted;

   assign o_valid  = (state == FULL);
   assign can_load = !o_valid || o_ready;

   // When both request, the side that did not win last time goes first.
   always_comb begin
      gnt_vld = a_valid || b_valid;
      if (a_valid && b_valid)
         gnt_id = ~last_grant;
      else
         gnt_id = b_valid;
   end

   assign a_ready = !rst && can_load && gnt_vld && !gnt_id;
   assign b_ready = !rst && can_load && gnt_vld &&  gnt_id;
   assign accept  = a_ready || b_ready;

   always_comb begin
      sel_bits  = gnt_id ? b_bits  : a_bits;
      sel_shift = gnt_id ? b_shift : a_shift;
      sel_left  = gnt_id ? b_left  : a_left;
      shifted   = '0;
      // Amounts at or beyond width only occur for non-power-of-2 widths and flush to zero.
      if (int'(sel_shift) < width)
         shifted = sel_left ? (sel_bits << sel_shift) : (sel_bits >> sel_shift);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         o_bits     <= '0;
         o_id       <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         state      <= FULL;
         o_bits     <= shifted;
         o_id       <= gnt_id;
         last_grant <= gnt_id;
      end else if (o_valid && o_ready) begin
         state      <= EMPTY;
      end
   end

endmodule

// File: tb/tb_lr_shift_arbiter.sv
// Directed bench for lr_shift_arbiter: expected results queued by stimulus, consumed by a monitor.
module tb_lr_shift_arbiter;

   typedef struct packed {
      logic [7:0] bits;
      logic       id;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_valid = 0, b_valid = 0, o_ready = 0;
   logic [7:0] a_bits = 0, b_bits = 0;
   logic [2:0] a_shift = 0, b_shift = 0;
   logic       a_left = 0, b_left = 0;
   logic       a_ready, b_ready, o_valid, o_id;
   logic [7:0] o_bits;

   logic       a6_valid = 0, o6_ready = 1;
   logic [5:0] a6_bits = 0;
   logic [2:0] a6_shift = 0;
   logic       a6_left = 0;
   logic       a6_ready, b6_ready, o6_valid, o6_id;
   logic [5:0] o6_bits;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   lr_shift_arbiter #(.width(8)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_bits(a_bits), .a_shift(a_shift), .a_left(a_left),
      .b_valid(b_valid), .b_ready(b_ready), .b_bits(b_bits), .b_shift(b_shift), .b_left(b_left),
      .o_valid(o_valid), .o_ready(o_ready), .o_bits(o_bits), .o_id(o_id)
   );

   lr_shift_arbiter #(.width(6)) u6 (
      .clk(clk), .rst(rst),
      .a_valid(a6_valid), .a_ready(a6_ready), .a_bits(a6_bits), .a_shift(a6_shift), .a_left(a6_left),
      .b_valid(1'b0), .b_ready(b6_ready), .b_bits(6'h00), .b_shift(3'd0), .b_left(1'b0),
      .o_valid(o6_valid), .o_ready(o6_ready), .o_bits(o6_bits), .o_id(o6_id)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] bits, input logic id);
      exp_t e;
      e.bits = bits;
      e.id   = id;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: a result is consumed on the edge following a negedge with valid && ready.
   always @(negedge clk) begin
      if (!rst && o_valid && o_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", {23'd0, o_bits, o_id}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_bits", o_bits, e.bits);
            chk("result_id", o_id, e.id);
         end
      end
      chk("one_hot_ready", a_ready && b_ready, 0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int  acc;
      bit  bgot;

      // Reset state, with A requesting to confirm readies are held low.
      a_valid = 1; a_bits = 8'hB4; a_shift = 2; a_left = 0; o_ready = 1;
      @(negedge clk);
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_bits", o_bits, 0);
      chk("rst_o_id", o_id, 0);
      chk("rst_a_ready", a_ready, 0);
      step();
      rst = 0;

      // A only: 0xB4 >> 2 = 0x2D
      push(8'h2D, 0);
      @(negedge clk);
      chk("a_only_a_ready", a_ready, 1);
      chk("a_only_b_ready", b_ready, 0);
      step();
      a_valid = 0;
      @(negedge clk);
      chk("a_only_o_valid", o_valid, 1);
      step();

      // B only, shift 0 left: pass-through, also moves the pointer to B.
      b_valid = 1; b_bits = 8'hA5; b_shift = 0; b_left = 1;
      push(8'hA5, 1);
      @(negedge clk);
      chk("b_only_b_ready", b_ready, 1);
      step();
      b_valid = 0;
      step();

      // Both valid every cycle: alternate A (0x81<<1) and B (0x81>>1).
      a_valid = 1; a_bits = 8'h81; a_shift = 1; a_left = 1;
      b_valid = 1; b_bits = 8'h81; b_shift = 1; b_left = 0;
      push(8'h02, 0); push(8'h40, 1); push(8'h02, 0); push(8'h40, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("alt_a_ready", a_ready, (i % 2 == 0));
         chk("alt_b_ready", b_ready, (i % 2 == 1));
         if (i > 0) chk("alt_o_valid", o_valid, 1);
         step();
      end
      a_valid = 0; b_valid = 0;
      step();

      // Backpressure: A (0xA5 >> 0) loads, then both stall for 5 cycles.
      o_ready = 0;
      a_valid = 1; a_bits = 8'hA5; a_shift = 0; a_left = 0;
      b_valid = 1; b_bits = 8'h80; b_shift = 7; b_left = 0;
      push(8'hA5, 0); push(8'h01, 1);
      @(negedge clk);
      chk("bp_first_a_ready", a_ready, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         chk("bp_a_ready", a_ready, 0);
         chk("bp_b_ready", b_ready, 0);
         chk("bp_o_valid", o_valid, 1);
         chk("bp_o_bits", o_bits, 8'hA5);
         chk("bp_o_id", o_id, 0);
      end
      step();
      o_ready = 1;
      @(negedge clk);
      chk("bp_release_b_ready", b_ready, 1);
      chk("bp_release_a_ready", a_ready, 0);
      step();
      b_valid = 0;
      a_bits = 8'hFF; a_shift = 7; a_left = 1;
      push(8'h80, 0);
      @(negedge clk);
      chk("bp_reload_o_valid", o_valid, 1);
      chk("bp_reload_a_ready", a_ready, 1);
      step();
      a_valid = 0;
      step();
      step();

      // Async reset with the slot full.
      o_ready = 0;
      a_valid = 1; a_bits = 8'h01; a_shift = 3; a_left = 1;
      step();
      a_valid = 0;
      @(negedge clk);
      chk("mid_full_o_valid", o_valid, 1);
      #2;
      rst = 1;
      #1;
      chk("async_rst_o_valid", o_valid, 0);
      chk("async_rst_o_bits", o_bits, 0);
      step();
      #2;
      rst = 0;
      o_ready = 1;
      a_valid = 1; a_bits = 8'h03; a_shift = 1; a_left = 1;
      b_valid = 1; b_bits = 8'hF0; b_shift = 4; b_left = 0;
      push(8'h06, 0); push(8'h0F, 1);
      @(negedge clk);
      chk("post_rst_a_first", a_ready, 1);
      step();
      @(negedge clk);
      chk("post_rst_b_second", b_ready, 1);
      step();
      a_valid = 0; b_valid = 0;
      step();

      // Fairness: B held, A keeps requesting.
      a_valid = 1; a_bits = 8'h11; a_shift = 4; a_left = 0;
      b_valid = 1; b_bits = 8'hC3; b_shift = 2; b_left = 1;
      push(8'h01, 0); push(8'h0C, 1);
      acc = 0; bgot = 0;
      for (int i = 0; i < 4 && !bgot; i++) begin
         @(negedge clk);
         if (a_ready) acc++;
         if (b_ready) begin bgot = 1; acc++; end
         step();
      end
      a_valid = 0; b_valid = 0;
      chk("fair_b_within_2", (bgot && acc <= 2), 1);
      step();
      step();

      // Width 6: shift amounts of 6 flush to zero in both directions.
      a6_valid = 1; a6_bits = 6'h3F; a6_shift = 6; a6_left = 1;
      step();
      a6_shift = 5;
      @(negedge clk);
      chk("w6_shift6_left_vld", o6_valid, 1);
      chk("w6_shift6_left", o6_bits, 0);
      step();
      a6_shift = 6; a6_left = 0;
      @(negedge clk);
      chk("w6_shift5_left", o6_bits, 6'h20);
      step();
      a6_valid = 0;
      @(negedge clk);
      chk("w6_shift6_right", o6_bits, 0);
      step();

      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
